// File: rtl/fetch_seq_unpack_if.sv
// rtl/fetch_seq_unpack_if.sv - job, memory-read and row-FIFO signals of fetch_seq_unpack
interface fetch_seq_unpack_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_waitrequest;
    logic [63:0]           mem_readdata;
    logic                  mem_readdatavalid;
    logic [NUM_ROWS-1:0]   fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic [NUM_ROWS-1:0]   fifo_full;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, mem_waitrequest, mem_readdata, mem_readdatavalid, fifo_full,
        output mem_read, mem_address, fifo_wr_en, fifo_wdata, busy, done
    );

    modport slave (
        output start, base_addr, mem_waitrequest, mem_readdata, mem_readdatavalid, fifo_full,
        input  mem_read, mem_address, fifo_wr_en, fifo_wdata, busy, done
    );
endinterface

// File: rtl/fetch_seq_unpack.sv
// rtl/fetch_seq_unpack.sv - fetches NUM_ROWS words, one read outstanding, and unpacks
// each word LSB byte first into its row FIFO
module fetch_seq_unpack #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 8
) (
    input logic               clk,
    input logic               rst,
    fetch_seq_unpack_if.master bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, DONE} state_t;

    state_t                state, state_nx;
    logic [ROW_W-1:0]      row, row_nx;
    logic [2:0]            byte_idx, byte_nx;
    logic [63:0]           hold, hold_nx;
    logic [ADDR_WIDTH-1:0] addr, addr_nx;
    logic                  mem_read_q, done_q, busy_q;
    logic                  wr_ok;
    logic [NUM_ROWS-1:0]   wr_en;
    logic [DATA_WIDTH-1:0] wdata;

    // Strobe is qualified by the live full flag so it can never land in a full FIFO.
    always_comb begin
        wr_ok = (state == UNPACK) && !bus.fifo_full[row];
        wr_en = '0;
        wdata = '0;
        if (wr_ok) begin
            wr_en[row] = 1'b1;
            wdata      = hold[{byte_idx, 3'b000} +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_nx = state;
        row_nx   = row;
        byte_nx  = byte_idx;
        hold_nx  = hold;
        addr_nx  = addr;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_nx  = bus.base_addr;
                    row_nx   = '0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (!bus.mem_waitrequest) state_nx = WAIT;
            end
            WAIT: begin
                if (bus.mem_readdatavalid) begin
                    hold_nx  = bus.mem_readdata;
                    byte_nx  = 3'd0;
                    state_nx = UNPACK;
                end
            end
            UNPACK: begin
                if (wr_ok) begin
                    byte_nx = byte_idx + 3'd1;
                    if (byte_idx == 3'd7) begin
                        if (row == LAST_ROW) begin
                            state_nx = DONE;
                        end else begin
                            // Address tracks base + row and wraps naturally at the top.
                            row_nx   = row + ROW_W'(1);
                            addr_nx  = addr + ADDR_WIDTH'(1);
                            state_nx = REQ;
                        end
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            byte_idx   <= 3'd0;
            hold       <= '0;
            addr       <= '0;
            mem_read_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            byte_idx   <= byte_nx;
            hold       <= hold_nx;
            addr       <= addr_nx;
            mem_read_q <= (state_nx == REQ);
            done_q     <= (state_nx == DONE);
            busy_q     <= (state_nx != IDLE);
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = addr;
    assign bus.fifo_wr_en  = wr_en;
    assign bus.fifo_wdata  = wdata;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
